// File: rtl/ili9341_display_sequencer.sv
// ILI9341 power-up and frame streaming command source for spi_controller.
// Define SEQ_TEST_PATTERN_EN to replace pixel_color with a coordinate gradient for panel bring-up.

package spi_types_pkg;
  typedef enum logic [2:0] {
    WRITE_8,
    WRITE_16,
    WRITE_8_READ_8,
    WRITE_8_READ_16,
    WRITE_8_READ_24
  } spi_transaction_t;
endpackage

module ili9341_display_sequencer
  import spi_types_pkg::*;
#(
  parameter int WIDTH        = 240,
  parameter int HEIGHT       = 320,
  parameter int RESET_CYCLES = 12000,
  parameter int DELAY_UNIT   = 12000
) (
  input  logic                      clk,
  input  logic                      rst,
  output spi_transaction_t          spi_mode,
  output logic                      spi_i_valid,
  output logic [15:0]               spi_i_data,
  input  logic                      spi_i_ready,
  output logic                      data_commandb,
  output logic                      display_rstb,
  output logic [$clog2(WIDTH)-1:0]  pixel_x,
  output logic [$clog2(HEIGHT)-1:0] pixel_y,
  input  logic [15:0]               pixel_color,
  output logic                      init_done,
  output logic                      frame_done
);

  localparam int XW = $clog2(WIDTH);
  localparam int YW = $clog2(HEIGHT);
  localparam logic [31:0]   RESET_LAST = 32'(RESET_CYCLES - 1);
  localparam logic [XW-1:0] X_LAST     = XW'(WIDTH - 1);
  localparam logic [YW-1:0] Y_LAST     = YW'(HEIGHT - 1);
  localparam logic [15:0]   COL_END    = 16'(WIDTH - 1);
  localparam logic [15:0]   ROW_END    = 16'(HEIGHT - 1);

  typedef enum logic [2:0] {
    S_HW_RESET, S_HW_WAKE, S_INIT_FETCH, S_DELAY, S_RAMWR, S_PIXEL, S_SEND, S_WAIT
  } state_t;

  typedef enum logic [1:0] {K_CMD, K_DATA, K_DELAY, K_END} entry_kind_t;

  // Remembers what the in-flight transfer was so S_WAIT knows where to go next.
  typedef enum logic [1:0] {P_INIT, P_RAMWR, P_PIXEL} phase_t;

  state_t           state, state_d;
  phase_t           phase, phase_d;
  logic [31:0]      counter, counter_d;
  logic [4:0]       index, index_d;
  entry_kind_t      entry_kind;
  logic [7:0]       entry_byte;
  logic [15:0]      pixel_word;
  logic             valid_d, dc_d, rstb_d, init_done_d, frame_done_d;
  logic [15:0]      data_d;
  spi_transaction_t mode_d;
  logic [XW-1:0]    x_d;
  logic [YW-1:0]    y_d;

`ifdef SEQ_TEST_PATTERN_EN
  logic unused_pixel_color;
  assign unused_pixel_color = ^pixel_color;
  assign pixel_word = {5'(pixel_x), 6'(pixel_y), 5'(pixel_x)};
`else
  assign pixel_word = pixel_color;
`endif

  always_comb begin
    entry_kind = K_END;
    entry_byte = 8'h00;
    case (index)
      5'd0:  begin entry_kind = K_CMD;   entry_byte = 8'h01; end
      5'd1:  begin entry_kind = K_DELAY; entry_byte = 8'd5; end
      5'd2:  begin entry_kind = K_CMD;   entry_byte = 8'h11; end
      5'd3:  begin entry_kind = K_DELAY; entry_byte = 8'd120; end
      5'd4:  begin entry_kind = K_CMD;   entry_byte = 8'h3A; end
      5'd5:  begin entry_kind = K_DATA;  entry_byte = 8'h55; end
      5'd6:  begin entry_kind = K_CMD;   entry_byte = 8'h36; end
      5'd7:  begin entry_kind = K_DATA;  entry_byte = 8'h48; end
      5'd8:  begin entry_kind = K_CMD;   entry_byte = 8'h2A; end
      5'd9:  begin entry_kind = K_DATA;  entry_byte = 8'h00; end
      5'd10: begin entry_kind = K_DATA;  entry_byte = 8'h00; end
      5'd11: begin entry_kind = K_DATA;  entry_byte = COL_END[15:8]; end
      5'd12: begin entry_kind = K_DATA;  entry_byte = COL_END[7:0]; end
      5'd13: begin entry_kind = K_CMD;   entry_byte = 8'h2B; end
      5'd14: begin entry_kind = K_DATA;  entry_byte = 8'h00; end
      5'd15: begin entry_kind = K_DATA;  entry_byte = 8'h00; end
      5'd16: begin entry_kind = K_DATA;  entry_byte = ROW_END[15:8]; end
      5'd17: begin entry_kind = K_DATA;  entry_byte = ROW_END[7:0]; end
      5'd18: begin entry_kind = K_CMD;   entry_byte = 8'h29; end
      5'd19: begin entry_kind = K_DELAY; entry_byte = 8'd20; end
      default: begin entry_kind = K_END; entry_byte = 8'h00; end
    endcase
  end

  always_comb begin
    state_d      = state;
    phase_d      = phase;
    counter_d    = counter;
    index_d      = index;
    valid_d      = spi_i_valid;
    data_d       = spi_i_data;
    mode_d       = spi_mode;
    dc_d         = data_commandb;
    rstb_d       = display_rstb;
    x_d          = pixel_x;
    y_d          = pixel_y;
    init_done_d  = init_done;
    frame_done_d = 1'b0;
    case (state)
      S_HW_RESET: begin
        if (counter == RESET_LAST) begin
          counter_d = '0;
          rstb_d    = 1'b1;
          state_d   = S_HW_WAKE;
        end else begin
          counter_d = counter + 32'd1;
        end
      end
      S_HW_WAKE: begin
        if (counter == RESET_LAST) begin
          counter_d = '0;
          state_d   = S_INIT_FETCH;
        end else begin
          counter_d = counter + 32'd1;
        end
      end
      S_INIT_FETCH: begin
        case (entry_kind)
          K_CMD, K_DATA: begin
            data_d  = {8'h00, entry_byte};
            mode_d  = WRITE_8;
            dc_d    = (entry_kind == K_DATA);
            valid_d = 1'b1;
            phase_d = P_INIT;
            state_d = S_SEND;
          end
          K_DELAY: begin
            counter_d = 32'(entry_byte) * 32'(DELAY_UNIT);
            state_d   = S_DELAY;
          end
          default: begin
            init_done_d = 1'b1;
            state_d     = S_RAMWR;
          end
        endcase
      end
      S_DELAY: begin
        if (counter == 32'd0) begin
          index_d = index + 5'd1;
          state_d = S_INIT_FETCH;
        end else begin
          counter_d = counter - 32'd1;
        end
      end
      S_RAMWR: begin
        data_d  = 16'h002C;
        mode_d  = WRITE_8;
        dc_d    = 1'b0;
        valid_d = 1'b1;
        phase_d = P_RAMWR;
        state_d = S_SEND;
      end
      S_PIXEL: begin
        data_d  = pixel_word;
        mode_d  = WRITE_16;
        dc_d    = 1'b1;
        valid_d = 1'b1;
        phase_d = P_PIXEL;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (spi_i_valid && spi_i_ready) begin
          valid_d = 1'b0;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        // Ready returning high after acceptance means the byte/word is fully on the wire.
        if (spi_i_ready) begin
          case (phase)
            P_INIT: begin
              index_d = index + 5'd1;
              state_d = S_INIT_FETCH;
            end
            P_RAMWR: state_d = S_PIXEL;
            default: begin
              if (pixel_x == X_LAST) begin
                x_d = '0;
                if (pixel_y == Y_LAST) begin
                  y_d          = '0;
                  frame_done_d = 1'b1;
                  state_d      = S_RAMWR;
                end else begin
                  y_d     = pixel_y + YW'(1);
                  state_d = S_PIXEL;
                end
              end else begin
                x_d     = pixel_x + XW'(1);
                state_d = S_PIXEL;
              end
            end
          endcase
        end
      end
      default: state_d = S_HW_RESET;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_HW_RESET;
      phase         <= P_INIT;
      counter       <= '0;
      index         <= '0;
      spi_i_valid   <= 1'b0;
      spi_i_data    <= '0;
      spi_mode      <= WRITE_8;
      data_commandb <= 1'b0;
      display_rstb  <= 1'b0;
      pixel_x       <= '0;
      pixel_y       <= '0;
      init_done     <= 1'b0;
      frame_done    <= 1'b0;
    end else begin
      state         <= state_d;
      phase         <= phase_d;
      counter       <= counter_d;
      index         <= index_d;
      spi_i_valid   <= valid_d;
      spi_i_data    <= data_d;
      spi_mode      <= mode_d;
      data_commandb <= dc_d;
      display_rstb  <= rstb_d;
      pixel_x       <= x_d;
      pixel_y       <= y_d;
      init_done     <= init_done_d;
      frame_done    <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_ili9341_display_sequencer.sv
// Bench for ili9341_display_sequencer: transaction-level model of init table and frames, busy SPI responder.
// Also covers the SEQ_TEST_PATTERN_EN build when that macro is defined for both files.

module tb_ili9341_display_sequencer;
  import spi_types_pkg::*;

  localparam int W = 4;
  localparam int H = 2;
  localparam int R = 4;
  localparam int DU = 2;
  localparam int BUSY = 20;
  localparam int INIT_LEN = 17;
  localparam int FRAME_LEN = W * H + 1;
  localparam logic [15:0] COL_END = 16'(W - 1);
  localparam logic [15:0] ROW_END = 16'(H - 1);
  // {dc, byte} for every SPI byte of the init table, delays removed.
  localparam logic [8:0] INIT_TAB [INIT_LEN] = '{
    9'h001, 9'h011, 9'h03A, 9'h155, 9'h036, 9'h148, 9'h02A, 9'h100, 9'h100,
    {1'b1, COL_END[15:8]}, {1'b1, COL_END[7:0]}, 9'h02B, 9'h100, 9'h100,
    {1'b1, ROW_END[15:8]}, {1'b1, ROW_END[7:0]}, 9'h029};

  typedef struct packed {
    logic [15:0] data;
    logic        dc;
    logic        wide;
    logic        pixel;
    logic [15:0] x;
    logic [15:0] y;
  } txn_t;

  logic clk, rst;
  spi_transaction_t spi_mode;
  logic spi_i_valid, spi_i_ready, data_commandb, display_rstb, init_done, frame_done;
  logic [15:0] spi_i_data, pixel_color;
  logic [$clog2(W)-1:0] pixel_x;
  logic [$clog2(H)-1:0] pixel_y;

  int total = 0;
  int bad = 0;
  int acc_count = 0;
  int fd_count = 0;
  int hold_max = 0;
  int run_id = 0;
  logic stall_armed = 1'b0;
  logic [16:0] first_log [0:63];
  int gaps [0:63];

  ili9341_display_sequencer #(
    .WIDTH(W), .HEIGHT(H), .RESET_CYCLES(R), .DELAY_UNIT(DU)
  ) dut (
    .clk(clk), .rst(rst), .spi_mode(spi_mode), .spi_i_valid(spi_i_valid),
    .spi_i_data(spi_i_data), .spi_i_ready(spi_i_ready), .data_commandb(data_commandb),
    .display_rstb(display_rstb), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_color(pixel_color), .init_done(init_done), .frame_done(frame_done)
  );

  // Frame buffer stand-in: a colour that encodes the requested address.
  assign pixel_color = 16'hF800 + 16'(pixel_y) * 16'(W) + 16'(pixel_x);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic txn_t model_txn(input int n);
    txn_t t;
    int m, r, p;
    t = '0;
    if (n < INIT_LEN) begin
      t.data = {8'h00, INIT_TAB[n][7:0]};
      t.dc = INIT_TAB[n][8];
    end else begin
      m = n - INIT_LEN;
      r = m % FRAME_LEN;
      if (r == 0) begin
        t.data = 16'h002C;
      end else begin
        p = r - 1;
        t.x = 16'(p % W);
        t.y = 16'(p / W);
        t.dc = 1'b1;
        t.wide = 1'b1;
        t.pixel = 1'b1;
`ifdef SEQ_TEST_PATTERN_EN
        t.data = {t.x[4:0], t.y[5:0], t.x[4:0]};
`else
        t.data = 16'hF800 + 16'(p / W * W + p % W);
`endif
      end
    end
    return t;
  endfunction

  function automatic int gap_required(input int n);
    case (n)
      1: return 5 * DU;
      2: return 120 * DU;
      INIT_LEN: return 20 * DU;
      default: return 0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic rst_value);
    @(negedge clk);
    #1 rst = rst_value;
  endtask

  task automatic waitAccepts(input int target, input int budget, input string what);
    int n = 0;
    while (acc_count < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput(what, 32'(acc_count >= target), 32'd1);
  endtask

  // SPI responder: ready drops for BUSY cycles after each acceptance; optional one-shot 50-cycle stall.
  initial begin
    logic hs;
    int busy, stall_left;
    logic just_rel;
    spi_i_ready = 1'b1;
    busy = 0;
    stall_left = 0;
    just_rel = 1'b0;
    forever begin
      @(negedge clk);
      hs = spi_i_valid && spi_i_ready;
      @(posedge clk);
      #2;
      if (!rst) begin
        spi_i_ready = 1'b1; busy = 0; stall_left = 0; just_rel = 1'b0;
      end else if (hs) begin
        spi_i_ready = 1'b0; busy = BUSY; just_rel = 1'b0;
      end else if (stall_left > 0) begin
        stall_left--;
        if (stall_left == 0) spi_i_ready = 1'b1;
      end else if (busy > 0) begin
        busy--;
        if (busy == 0) begin
          spi_i_ready = 1'b1;
          just_rel = 1'b1;
        end
      end else if (just_rel) begin
        just_rel = 1'b0;
        if (stall_armed) begin
          stall_armed = 1'b0;
          spi_i_ready = 1'b0;
          stall_left = 50;
        end
      end
    end
  end

  // Compare process: every negedge, DUT outputs against the transaction model.
  initial begin
    int cyc, since_rel, last_acc_cyc, hold_run, f;
    logic in_flight, prev_pend, prev_fd, seen_init;
    logic [19:0] prev_word;
    txn_t cur, want;
    cyc = 0; since_rel = 0; last_acc_cyc = 0; hold_run = 0;
    in_flight = 0; prev_pend = 0; prev_fd = 0; seen_init = 0;
    prev_word = '0; cur = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        checkOutput("reset_ctrl", {25'd0, spi_i_valid, data_commandb, display_rstb, init_done,
                    frame_done, |pixel_x, |pixel_y}, 32'd0);
        checkOutput("reset_data", {13'd0, 3'(spi_mode), spi_i_data}, {13'd0, 3'(WRITE_8), 16'h0000});
        since_rel = 0; acc_count = 0; fd_count = 0; in_flight = 0; prev_pend = 0;
        prev_fd = 0; seen_init = 0; hold_run = 0; last_acc_cyc = cyc;
      end else begin
        since_rel++;
        checkOutput("display_rstb", 32'(display_rstb), 32'(since_rel >= R));
        if (since_rel < 2 * R) checkOutput("early_valid", 32'(spi_i_valid), 32'd0);
        if (in_flight) begin
          checkOutput("valid_in_wait", 32'(spi_i_valid), 32'd0);
          checkOutput("wait_hold_dc_xy", {15'd0, data_commandb, 8'(pixel_x), 8'(pixel_y)},
                      {15'd0, cur.dc, cur.x[7:0], cur.y[7:0]});
          if (spi_i_ready) in_flight = 1'b0;
        end
        if (prev_pend)
          checkOutput("request_hold", {11'd0, spi_i_valid, data_commandb, 3'(spi_mode), spi_i_data},
                      {11'd0, 1'b1, prev_word});
        prev_pend = spi_i_valid && !spi_i_ready;
        prev_word = {data_commandb, 3'(spi_mode), spi_i_data};
        hold_run = prev_pend ? hold_run + 1 : 0;
        if (hold_run > hold_max) hold_max = hold_run;
        if (frame_done) begin
          fd_count++;
          checkOutput("frame_done_single", 32'(prev_fd), 32'd0);
          checkOutput("frame_done_place", 32'(acc_count > INIT_LEN &&
                      (acc_count - INIT_LEN) % FRAME_LEN == 0), 32'd1);
        end
        prev_fd = frame_done;
        if (seen_init) checkOutput("init_done_sticky", 32'(init_done), 32'd1);
        seen_init = seen_init | init_done;
        if (spi_i_valid && spi_i_ready) begin
          want = model_txn(acc_count);
          checkOutput($sformatf("txn%0d", acc_count), {12'd0, data_commandb, 3'(spi_mode), spi_i_data},
                      {12'd0, want.dc, want.wide ? 3'(WRITE_16) : 3'(WRITE_8), want.data});
          if (want.pixel)
            checkOutput("pixel_xy", {16'(pixel_x), 16'(pixel_y)}, {want.x, want.y});
          checkOutput("init_done_at_txn", 32'(init_done), 32'(acc_count >= INIT_LEN));
          if (gap_required(acc_count) > 0)
            checkOutput("delay_gap", 32'(cyc - last_acc_cyc >= gap_required(acc_count)), 32'd1);
          if (acc_count >= INIT_LEN && !want.pixel) begin
            f = (acc_count - INIT_LEN) / FRAME_LEN;
            checkOutput("frame_done_count", 32'(fd_count), 32'(f));
          end
          if (run_id == 0 && acc_count < 64) begin
            first_log[acc_count] = {data_commandb, spi_i_data};
            gaps[acc_count] = cyc - last_acc_cyc;
          end
          cur = want;
          in_flight = 1'b1;
          last_acc_cyc = cyc;
          acc_count++;
        end
      end
    end
  end

  initial begin
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("held_reset_rstb", 32'(display_rstb), 32'd0);
    checkOutput("held_reset_valid", 32'(spi_i_valid), 32'd0);
    applyStimulus(1'b1);

    waitAccepts(5, 3000, "reach_init_36");
    stall_armed = 1'b1;
    waitAccepts(INIT_LEN + 1, 5000, "reach_ramwr");
    waitAccepts(INIT_LEN + 2 * FRAME_LEN + 6, 8000, "reach_frame3_pixel5");

    checkOutput("log_01", 32'(first_log[0]), 32'h00001);
    checkOutput("log_3A", 32'(first_log[2]), 32'h0003A);
    checkOutput("log_col_end", 32'(first_log[10]), 32'h10003);
    checkOutput("log_row_end", 32'(first_log[15]), 32'h10001);
    checkOutput("log_2C_first", 32'(first_log[17]), 32'h0002C);
`ifdef SEQ_TEST_PATTERN_EN
    checkOutput("log_px00", 32'(first_log[18]), 32'h10000);
    checkOutput("log_px31", 32'(first_log[25]), 32'h11823);
`else
    checkOutput("log_px00", 32'(first_log[18]), 32'h1F800);
    checkOutput("log_px31", 32'(first_log[25]), 32'h1F807);
`endif
    checkOutput("log_2C_second", 32'(first_log[26]), 32'h0002C);
    checkOutput("gap_after_11", 32'(gaps[2] >= 240), 32'd1);
    checkOutput("hold_cycles", 32'(hold_max >= 45), 32'd1);
    checkOutput("frames_done", 32'(fd_count), 32'd2);

    repeat (2) @(negedge clk);
    run_id = 1;
    applyStimulus(1'b0);
    @(negedge clk);
    checkOutput("abort_valid", 32'(spi_i_valid), 32'd0);
    checkOutput("abort_rstb", 32'(display_rstb), 32'd0);
    repeat (2) @(negedge clk);
    applyStimulus(1'b1);
    waitAccepts(INIT_LEN + 4, 5000, "replay_after_reset");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ili9341_display_sequencer.md
Name: ili9341_display_sequencer

Overview:
- Upstream command source for spi_controller in the etch-a-sketch display path.
- After reset, it pulses the panel hardware reset, then plays a fixed ILI9341 init table as WRITE_8 transactions with data/command tagging and timed delays.
- It then streams full frames: a RAMWR command followed by WIDTH*HEIGHT WRITE_16 pixels.
- Pixel colours are requested from the frame-buffer side by (x,y) address.

Parameters:
- WIDTH, 240, pixels per row; CASET end column = WIDTH-1.
- HEIGHT, 320, rows per frame; PASET end row = HEIGHT-1.
- RESET_CYCLES, 12000, clk cycles display_rstb is held low.
- DELAY_UNIT, 12000, clk cycles per delay-table unit (1 ms at 12 MHz).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- spi_mode  out  spi_transaction_t  to spi_controller spi_mode.
- spi_i_valid  out  1  request valid to spi_controller.
- spi_i_data  out  16  transmit word to spi_controller.
- spi_i_ready  in  1  spi_controller ready.
- data_commandb  out  1  panel D/C pin: 1 = data, 0 = command.
- display_rstb  out  1  panel hardware reset, active low.
- pixel_x  out  $clog2(WIDTH)  column of the pixel being requested.
- pixel_y  out  $clog2(HEIGHT)  row of the pixel being requested.
- pixel_color  in  16  RGB565 for (pixel_x,pixel_y); must be valid in the same cycle.
- init_done  out  1  high once the init table has completed.
- frame_done  out  1  one-cycle pulse after the last pixel of each frame is accepted.

Behaviour:
- Reset values: spi_i_valid=0, spi_i_data=0, spi_mode=WRITE_8, data_commandb=0, display_rstb=0, pixel_x=0, pixel_y=0, init_done=0, frame_done=0. State = S_HW_RESET with counter cleared.
- Reset asserted mid-operation aborts immediately to the reset values. Any in-flight SPI transfer is abandoned; spi_controller is reset from the same source.
- Init table, fixed, one entry per step {kind, byte}. Kinds: CMD (dc=0), DATA (dc=1), DELAY (byte*DELAY_UNIT cycles), END. Contents in order:
  - CMD 01; DELAY 5; CMD 11; DELAY 120
  - CMD 3A, DATA 55; CMD 36, DATA 48
  - CMD 2A, DATA 00, 00, (WIDTH-1)[15:8], (WIDTH-1)[7:0]
  - CMD 2B, DATA 00, 00, (HEIGHT-1)[15:8], (HEIGHT-1)[7:0]
  - CMD 29; DELAY 20; END
- States and transitions:
  - S_HW_RESET: display_rstb=0 for RESET_CYCLES cycles, then display_rstb<=1 -> S_HW_WAKE.
  - S_HW_WAKE: wait RESET_CYCLES cycles -> S_INIT_FETCH.
  - S_INIT_FETCH: read entry at index. CMD/DATA: load spi_i_data={8'h00,byte}, spi_mode=WRITE_8, set data_commandb, spi_i_valid<=1 -> S_SEND. DELAY: load counter -> S_DELAY. END: init_done<=1 -> S_RAMWR.
  - S_DELAY: count down to 0; index++ -> S_INIT_FETCH. DELAY 0 takes exactly one cycle.
  - S_RAMWR: issue CMD 2C (dc=0, WRITE_8) -> S_SEND.
  - S_PIXEL: issue spi_i_data=pixel_color, WRITE_16, dc=1 -> S_SEND.
  - S_SEND: hold valid, data, mode and dc stable until the cycle with spi_i_valid && spi_i_ready. On that edge spi_i_valid<=0 -> S_WAIT.
  - S_WAIT: wait until spi_i_ready=1, which marks the transfer complete. spi_i_ready is low the cycle after acceptance. Then advance to the next init entry, S_PIXEL, or the pixel counter update.
- Pixel counters advance after each pixel completes: x++; at x=WIDTH-1, x wraps to 0 and y++. At (WIDTH-1,HEIGHT-1), both wrap to 0, frame_done pulses for one cycle, and the next state is S_RAMWR, so every frame is re-prefixed with 2C.
- data_commandb changes only when a new request is loaded. It is never changed while csb could be low.
- pixel_x/pixel_y are stable from S_PIXEL entry until that pixel completes.
- spi_i_valid is never asserted while in S_WAIT or S_DELAY.

Optional Feature:
- Macro SEQ_TEST_PATTERN_EN.
- Defined: pixel_color is ignored; each pixel sends {pixel_x[4:0], pixel_y[5:0], pixel_x[4:0]}, a gradient pattern for panel bring-up.
- Undefined: pixel_color is sent unmodified.
- Interface is identical in both builds.

Test Plan:
- Reset release with RESET_CYCLES=4: display_rstb low 4 cycles after rst rises, high thereafter; no spi_i_valid before cycle 8.
- Init playback, DELAY_UNIT=2, spi_i_ready model with 20-cycle busy: accepted bytes 01,11,3A,55,36,48,2A,00,00,00,EF,2B,00,00,01,3F,29,2C. dc=0 exactly on 01,11,3A,36,2A,2B,29,2C. Gap after 11 is >=240 cycles.
- Valid hold: spi_i_ready held low 50 cycles during a request -> spi_i_valid, spi_i_data and data_commandb unchanged throughout; exactly one acceptance.
- Frame streaming, WIDTH=4, HEIGHT=2, pixel_color=16'hF800: 8 WRITE_16 transfers of F800, dc=1. x,y sequence (0,0)..(3,0),(0,1)..(3,1). One frame_done pulse, then the next accepted word is 2C with dc=0.
- Mid-transfer reset: assert rst low during the 5th pixel -> all outputs at reset values next cycle; after release, sequence restarts at S_HW_RESET and replays the full init table.
- SEQ_TEST_PATTERN_EN build, WIDTH=4, HEIGHT=2: pixel (3,1) sends 16'h1823 regardless of pixel_color.
